cube_spawner: RTL and testbench
===============================

Name: cube_spawner

Overview:
Upstream stage of the falling-cube block. It decides when each cube launches, where it launches, and how fast it falls. It generates a one-cycle start pulse together with a pseudo-random initial X position and a fall speed, then waits for the cube to report completion before scheduling the next one. Speed rises with the number of completed cubes. A frame-count delay separates consecutive launches.

Parameters:
SPAWN_DELAY_FRAMES, 30, number of frame pulses spent in WAIT before each launch (must be >= 1)
CUBES_PER_LEVEL, 4, completed cubes needed to raise speed by one step
X_MAX, 447, largest legal initial X (cube width 64 must stay on screen)
LFSR_SEED, 16'hACE1, LFSR reset value (must be nonzero)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
pixel_x  in  10  current pixel column from the VGA sync generator
pixel_y  in  10  current pixel row from the VGA sync generator
juego_activo  in  1  level-sensitive game-run enable
terminadoCubo  in  1  one-cycle pulse from the cube block when its fall has finished
start  out  1  one-cycle launch pulse to the cube block
posicion_x_inicial_aleatoria  out  9  initial X position of the cube, registered
velocidad_cubo_in  out  2  fall speed in pixels per frame, registered, range 1..3
cubos_completados  out  8  count of completed cubes, saturates at 255

Behaviour:
- One clock; all state updates on the posedge of clk.
- Synchronous reset values: state IDLE, start=0, posicion_x_inicial_aleatoria=0, velocidad_cubo_in=1, cubos_completados=0, frame counter=0, level counter=0, LFSR=LFSR_SEED.
- Frame pulse: frame_tick = (pixel_y==481 && pixel_x==0), computed combinationally.
- LFSR: 16-bit Fibonacci with taps 16,14,13,11. It is free-running and shifts every non-reset cycle. It never reaches the all-zero state.
- X fold rule: raw = lfsr[8:0]. If raw > X_MAX, then x = raw - (X_MAX+1); otherwise x = raw. With the default X_MAX, x is always in 0..447.
- State IDLE: start=0. If juego_activo=1, clear the frame counter and go to WAIT.
- State WAIT:
  - If juego_activo=0, go to IDLE. This takes priority over frame_tick.
  - Otherwise, on each frame_tick, increment the frame counter.
  - On the frame_tick where counter == SPAWN_DELAY_FRAMES-1, go to LAUNCH. On that same transition edge, register x from the current LFSR value and register the speed.
- State LAUNCH: lasts exactly one cycle. start=1, and the outputs registered on entry are valid in this same cycle. Next state is ACTIVE.
- State ACTIVE: start=0 and the outputs are held stable.
  - Wait for terminadoCubo. A cube cannot be aborted, so a drop of juego_activo is ignored while in ACTIVE.
  - When terminadoCubo=1:
    - cubos_completados increments, saturating at 255.
    - The level counter increments. When it reaches CUBES_PER_LEVEL, it clears and the speed step rises.
    - Next state is WAIT (frame counter cleared) if juego_activo=1, otherwise IDLE.
- Speed rule: velocidad_cubo_in = min(1 + levels_reached, 3). It is never 0, because a speed of 0 would stall the cube forever. A speed increase applies starting with the next launch.
- terminadoCubo outside ACTIVE is ignored. frame_tick outside WAIT is ignored.
- Reset asserted in any state returns all registers to their reset values on the next edge. A pending start is never emitted.
- Latency from terminadoCubo to the next start: SPAWN_DELAY_FRAMES frame pulses, plus 1 cycle.
- Outputs posicion_x_inicial_aleatoria and velocidad_cubo_in change only on the edge that enters LAUNCH, or on reset.

Test Plan:
- Reset, hold juego_activo=0 for 3 frames -> start never asserts; outputs stay at 0, 1, and 0 (x, speed, count).
- SPAWN_DELAY_FRAMES=2, raise juego_activo -> start is high for exactly 1 cycle, on the cycle after the 2nd frame_tick; velocidad_cubo_in=1.
- Force the LFSR so that lfsr[8:0]=500 at launch -> posicion_x_inicial_aleatoria=52. With lfsr[8:0]=447 -> x=447.
- CUBES_PER_LEVEL=4, drive 12 terminadoCubo pulses, each one while in ACTIVE:
  - Speed is 1 for launches 1-4, 2 for launches 5-8, and 3 from launch 9 onward, staying at 3 after 12.
  - cubos_completados=12.
- Drop juego_activo during ACTIVE -> state holds until terminadoCubo, then goes to IDLE with no further start. Drop it during WAIT on the same cycle as frame_tick -> goes to IDLE with no start.
- Assert reset on the LAUNCH cycle and pulse terminadoCubo in IDLE -> no start afterwards, cubos_completados=0, LFSR equals LFSR_SEED.

Source files
------------

// File: rtl/cube_spawner.sv
// cube_spawner: schedules falling-cube launches. After a frame-count delay it
// pulses start for one cycle with a pseudo-random X and a level-based speed.
// It then waits for the cube to report completion before scheduling the next launch.
module cube_spawner #(
    parameter int          SPAWN_DELAY_FRAMES = 30,
    parameter int          CUBES_PER_LEVEL    = 4,
    parameter int          X_MAX              = 447,
    parameter logic [15:0] LFSR_SEED          = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       juego_activo,
    input  logic       terminadoCubo,
    output logic       start,
    output logic [8:0] posicion_x_inicial_aleatoria,
    output logic [1:0] velocidad_cubo_in,
    output logic [7:0] cubos_completados
);

    localparam int FW = (SPAWN_DELAY_FRAMES < 1) ? 1 : $clog2(SPAWN_DELAY_FRAMES + 1);
    localparam int LW = (CUBES_PER_LEVEL < 1) ? 1 : $clog2(CUBES_PER_LEVEL + 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(SPAWN_DELAY_FRAMES - 1);
    localparam logic [LW-1:0] LEVEL_LAST = LW'(CUBES_PER_LEVEL - 1);
    localparam logic [8:0]    X_LIMIT    = 9'(X_MAX);
    localparam logic [8:0]    X_WRAP     = 9'(X_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_LAUNCH,
        S_ACTIVE
    } state_t;

    state_t state, next_state;

    logic [15:0]   lfsr;
    logic          lfsr_fb;
    logic [FW-1:0] frame_cnt;
    logic [LW-1:0] level_cnt;
    logic [1:0]    levels_reached;
    logic          frame_tick;
    logic          frame_clear;
    logic          frame_inc;
    logic          load_launch;
    logic          cube_done;
    logic [8:0]    x_raw;
    logic [8:0]    x_folded;
    logic [1:0]    speed_next;

    // Frame pulse once per frame, just after the visible area; the fold maps the
    // 9-bit LFSR slice into the legal X range; speed is clamped to 1..3.
    always_comb begin
        frame_tick = (pixel_y == 10'd481) && (pixel_x == 10'd0);
        lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
        x_raw      = lfsr[8:0];
        x_folded   = (x_raw > X_LIMIT) ? (x_raw - X_WRAP) : x_raw;
        speed_next = (levels_reached >= 2'd2) ? 2'd3 : (levels_reached + 2'd1);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    // Next-state logic and per-state control strobes.
    always_comb begin
        next_state  = state;
        start       = 1'b0;
        frame_clear = 1'b0;
        frame_inc   = 1'b0;
        load_launch = 1'b0;
        cube_done   = 1'b0;
        case (state)
            S_IDLE: begin
                if (juego_activo) begin
                    frame_clear = 1'b1;
                    next_state  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!juego_activo) begin
                    next_state = S_IDLE;
                end else if (frame_tick) begin
                    if (frame_cnt == FRAME_LAST) begin
                        load_launch = 1'b1;
                        frame_clear = 1'b1;
                        next_state  = S_LAUNCH;
                    end else begin
                        frame_inc = 1'b1;
                    end
                end
            end
            S_LAUNCH: begin
                start      = 1'b1;
                next_state = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (terminadoCubo) begin
                    cube_done = 1'b1;
                    if (juego_activo) begin
                        frame_clear = 1'b1;
                        next_state  = S_WAIT;
                    end else begin
                        next_state = S_IDLE;
                    end
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Free-running Fibonacci LFSR; nonzero seed keeps it out of the all-zero lockup.
    always_ff @(posedge clk) begin
        if (reset) lfsr <= LFSR_SEED;
        else       lfsr <= {lfsr[14:0], lfsr_fb};
    end

    // Counts frame pulses spent in WAIT before a launch.
    always_ff @(posedge clk) begin
        if (reset)            frame_cnt <= '0;
        else if (frame_clear) frame_cnt <= '0;
        else if (frame_inc)   frame_cnt <= frame_cnt + 1'b1;
    end

    // Launch parameters are captured only on the edge entering LAUNCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            posicion_x_inicial_aleatoria <= 9'd0;
            velocidad_cubo_in            <= 2'd1;
        end else if (load_launch) begin
            posicion_x_inicial_aleatoria <= x_folded;
            velocidad_cubo_in            <= speed_next;
        end
    end

    // Completed-cube bookkeeping: saturating total and per-level progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            cubos_completados <= 8'd0;
            level_cnt         <= '0;
            levels_reached    <= 2'd0;
        end else if (cube_done) begin
            if (cubos_completados != 8'd255)
                cubos_completados <= cubos_completados + 8'd1;
            if (level_cnt == LEVEL_LAST) begin
                level_cnt <= '0;
                if (levels_reached != 2'd2)
                    levels_reached <= levels_reached + 2'd1;
            end else begin
                level_cnt <= level_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cube_spawner.sv
// tb_cube_spawner: directed self-checking bench for cube_spawner with a short
// spawn delay of 2 frames and 4 cubes per level.
module tb_cube_spawner;

    logic       clk;
    logic       reset;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       juego_activo;
    logic       terminadoCubo;
    logic       start;
    logic [8:0] posicion_x_inicial_aleatoria;
    logic [1:0] velocidad_cubo_in;
    logic [7:0] cubos_completados;

    int checks      = 0;
    int errors      = 0;
    int completions = 0;
    int start_seen  = 0;

    cube_spawner #(
        .SPAWN_DELAY_FRAMES(2),
        .CUBES_PER_LEVEL   (4),
        .X_MAX             (447),
        .LFSR_SEED         (16'hACE1)
    ) dut (
        .clk                         (clk),
        .reset                       (reset),
        .pixel_x                     (pixel_x),
        .pixel_y                     (pixel_y),
        .juego_activo                (juego_activo),
        .terminadoCubo               (terminadoCubo),
        .start                       (start),
        .posicion_x_inicial_aleatoria(posicion_x_inicial_aleatoria),
        .velocidad_cubo_in           (velocidad_cubo_in),
        .cubos_completados           (cubos_completados)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts every cycle in which start is high, sampled mid-cycle.
    always @(negedge clk) begin
        if (start === 1'b1) start_seen++;
    end

    // Expected speed for a launch preceded by c completed cubes.
    function automatic logic [1:0] exp_speed(input int c);
        if (c >= 8)      return 2'd3;
        else if (c >= 4) return 2'd2;
        else             return 2'd1;
    endfunction

    // One frame pulse lasting exactly one rising edge; returns at the next negedge.
    task automatic do_frame();
        @(negedge clk);
        pixel_y = 10'd481;
        pixel_x = 10'd0;
        @(negedge clk);
        pixel_y = 10'd0;
    endtask

    // One-cycle completion pulse from the cube block.
    task automatic do_done();
        @(negedge clk);
        terminadoCubo = 1'b1;
        @(negedge clk);
        terminadoCubo = 1'b0;
        completions++;
    endtask

    task automatic test_reset();
        int base;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (dut.lfsr !== 16'hACE1) begin
            errors++;
            $display("[TB] FAIL reset_lfsr: got %h expected %h", dut.lfsr, 16'hACE1);
        end
        reset = 1'b0;
        @(negedge clk);
        base = start_seen;
        repeat (3) do_frame();
        repeat (2) @(negedge clk);
        checks++;
        if (start_seen !== base) begin
            errors++;
            $display("[TB] FAIL idle_no_start: got %0d starts expected 0", start_seen - base);
        end
        checks++;
        if (posicion_x_inicial_aleatoria !== 9'd0) begin
            errors++;
            $display("[TB] FAIL reset_x: got %0d expected 0", posicion_x_inicial_aleatoria);
        end
        checks++;
        if (velocidad_cubo_in !== 2'd1) begin
            errors++;
            $display("[TB] FAIL reset_speed: got %0d expected 1", velocidad_cubo_in);
        end
        checks++;
        if (cubos_completados !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_count: got %0d expected 0", cubos_completados);
        end
    endtask

    task automatic test_first_launch();
        int base;
        base = start_seen;
        @(negedge clk);
        juego_activo = 1'b1;
        do_frame();
        checks++;
        if (start !== 1'b0) begin
            errors++;
            $display("[TB] FAIL early_start: got %b expected 0", start);
        end
        do_frame();
        checks++;
        if (start !== 1'b1) begin
            errors++;
            $display("[TB] FAIL first_start: got %b expected 1", start);
        end
        checks++;
        if (velocidad_cubo_in !== 2'd1) begin
            errors++;
            $display("[TB] FAIL first_speed: got %0d expected 1", velocidad_cubo_in);
        end
        @(negedge clk);
        checks++;
        if (start !== 1'b0) begin
            errors++;
            $display("[TB] FAIL start_width: got %b expected 0", start);
        end
        checks++;
        if (start_seen - base !== 1) begin
            errors++;
            $display("[TB] FAIL start_count: got %0d expected 1", start_seen - base);
        end
    endtask

    task automatic test_x_fold();
        logic [8:0] exp_x[3] = '{9'd52, 9'd447, 9'd0};
        for (int i = 0; i < 3; i++) begin
            do_done();
            do_frame();
            @(negedge clk);
            pixel_y = 10'd481;
            case (i)
                0:       force dut.lfsr = 16'h01F4;
                1:       force dut.lfsr = 16'h01BF;
                default: force dut.lfsr = 16'h01C0;
            endcase
            @(negedge clk);
            pixel_y = 10'd0;
            release dut.lfsr;
            checks++;
            if (start !== 1'b1 || posicion_x_inicial_aleatoria !== exp_x[i]) begin
                errors++;
                $display("[TB] FAIL x_fold_%0d: got start=%b x=%0d expected start=1 x=%0d",
                         i, start, posicion_x_inicial_aleatoria, exp_x[i]);
            end
            checks++;
            if (velocidad_cubo_in !== exp_speed(completions)) begin
                errors++;
                $display("[TB] FAIL fold_speed_%0d: got %0d expected %0d",
                         i, velocidad_cubo_in, exp_speed(completions));
            end
            repeat (3) @(negedge clk);
            checks++;
            if (posicion_x_inicial_aleatoria !== exp_x[i]) begin
                errors++;
                $display("[TB] FAIL x_hold_%0d: got %0d expected %0d",
                         i, posicion_x_inicial_aleatoria, exp_x[i]);
            end
        end
    endtask

    task automatic test_speed();
        for (int i = 0; i < 9; i++) begin
            do_done();
            do_frame();
            do_frame();
            checks++;
            if (start !== 1'b1 || velocidad_cubo_in !== exp_speed(completions)) begin
                errors++;
                $display("[TB] FAIL speed_launch_%0d: got start=%b speed=%0d expected start=1 speed=%0d",
                         completions + 1, start, velocidad_cubo_in, exp_speed(completions));
            end
        end
        checks++;
        if (cubos_completados !== 8'd12) begin
            errors++;
            $display("[TB] FAIL count_12: got %0d expected 12", cubos_completados);
        end
    endtask

    task automatic test_drop_active();
        int base;
        @(negedge clk);
        juego_activo = 1'b0;
        base = start_seen;
        repeat (4) @(negedge clk);
        do_done();
        repeat (3) do_frame();
        checks++;
        if (cubos_completados !== 8'd13) begin
            errors++;
            $display("[TB] FAIL drop_active_count: got %0d expected 13", cubos_completados);
        end
        checks++;
        if (start_seen !== base) begin
            errors++;
            $display("[TB] FAIL drop_active_start: got %0d starts expected 0", start_seen - base);
        end
        checks++;
        if (velocidad_cubo_in !== 2'd3) begin
            errors++;
            $display("[TB] FAIL drop_active_speed: got %0d expected 3", velocidad_cubo_in);
        end
    endtask

    task automatic test_drop_wait();
        int base;
        base = start_seen;
        @(negedge clk);
        juego_activo = 1'b1;
        do_frame();
        @(negedge clk);
        pixel_y      = 10'd481;
        juego_activo = 1'b0;
        @(negedge clk);
        pixel_y = 10'd0;
        repeat (3) do_frame();
        checks++;
        if (start_seen !== base) begin
            errors++;
            $display("[TB] FAIL drop_wait_start: got %0d starts expected 0", start_seen - base);
        end
    endtask

    task automatic test_reset_launch();
        int base;
        @(negedge clk);
        juego_activo = 1'b1;
        do_frame();
        do_frame();
        checks++;
        if (start !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pre_reset_start: got %b expected 1", start);
        end
        reset        = 1'b1;
        juego_activo = 1'b0;
        @(negedge clk);
        checks++;
        if (start !== 1'b0 || cubos_completados !== 8'd0 || dut.lfsr !== 16'hACE1) begin
            errors++;
            $display("[TB] FAIL reset_on_launch: got start=%b count=%0d lfsr=%h expected start=0 count=0 lfsr=ace1",
                     start, cubos_completados, dut.lfsr);
        end
        checks++;
        if (posicion_x_inicial_aleatoria !== 9'd0 || velocidad_cubo_in !== 2'd1) begin
            errors++;
            $display("[TB] FAIL reset_on_launch_out: got x=%0d speed=%0d expected x=0 speed=1",
                     posicion_x_inicial_aleatoria, velocidad_cubo_in);
        end
        reset = 1'b0;
        base  = start_seen;
        @(negedge clk);
        terminadoCubo = 1'b1;
        @(negedge clk);
        terminadoCubo = 1'b0;
        repeat (3) do_frame();
        checks++;
        if (start_seen !== base || cubos_completados !== 8'd0) begin
            errors++;
            $display("[TB] FAIL idle_done_ignored: got starts=%0d count=%0d expected starts=0 count=0",
                     start_seen - base, cubos_completados);
        end
        completions = 0;
    endtask

    task automatic test_saturation();
        @(negedge clk);
        juego_activo = 1'b1;
        for (int i = 0; i < 257; i++) begin
            do_frame();
            do_frame();
            checks++;
            if (start !== 1'b1 || velocidad_cubo_in !== exp_speed(completions)) begin
                errors++;
                $display("[TB] FAIL sat_launch_%0d: got start=%b speed=%0d expected start=1 speed=%0d",
                         i, start, velocidad_cubo_in, exp_speed(completions));
            end
            do_done();
        end
        @(negedge clk);
        checks++;
        if (cubos_completados !== 8'd255) begin
            errors++;
            $display("[TB] FAIL count_saturate: got %0d expected 255", cubos_completados);
        end
    endtask

    initial begin
        reset         = 1'b1;
        pixel_x       = 10'd0;
        pixel_y       = 10'd0;
        juego_activo  = 1'b0;
        terminadoCubo = 1'b0;
        $display("[TB] cube_spawner bench starting");
        test_reset();
        test_first_launch();
        test_x_fold();
        test_speed();
        test_drop_active();
        test_drop_wait();
        test_reset_launch();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
